// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared LC-3b types and constants for the physical-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_memband;

  typedef enum logic [1:0] {
    arb_idle    = 2'd0,
    arb_grant_i = 2'd1,
    arb_grant_d = 2'd2,
    arb_recover = 2'd3
  } lc3b_arb_state;

  localparam lc3b_word lc3b_line_addr = 16'hFFF0;

  function automatic lc3b_word line_align(input lc3b_word addr);
    return addr & lc3b_line_addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_req_reg.sv
// ============================================================================
// Module   : arb_req_reg
// Purpose  : Enable-loaded capture of the granted request (address, op, wdata).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_req_reg
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  lc3b_word    addr_in,
  input  logic        write_in,
  input  lc3b_memband wdata_in,
  output lc3b_word    addr,
  output logic        write,
  output lc3b_memband wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      write <= 1'b0;
      wdata <= '0;
    end else if (load) begin
      addr  <= addr_in;
      write <= write_in;
      wdata <= wdata_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one line-wide memory port between
//            the I-cache and D-cache, with a saturating conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter bit I_FIRST   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pmem_read,
  input  lc3b_word             i_pmem_address,
  output lc3b_memband          i_pmem_rdata,
  output logic                 i_pmem_resp,
  input  logic                 d_pmem_read,
  input  logic                 d_pmem_write,
  input  lc3b_word             d_pmem_address,
  input  lc3b_memband          d_pmem_wdata,
  output lc3b_memband          d_pmem_rdata,
  output logic                 d_pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output lc3b_word             pmem_address,
  output lc3b_memband          pmem_wdata,
  input  lc3b_memband          pmem_rdata,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] conflict_count
);

  lc3b_arb_state state;
  lc3b_arb_state next_state;

  logic        i_req;
  logic        d_req;
  logic        conflict;
  logic        sel_i;
  logic        load;
  logic        last_grant_i;
  logic        op_write;
  lc3b_word    cap_addr;
  logic        cap_write;
  lc3b_memband cap_wdata;

  always_comb begin
    i_req    = i_pmem_read;
    d_req    = d_pmem_read | d_pmem_write;
    conflict = (state == arb_idle) && i_req && d_req;
    load     = (state == arb_idle) && (i_req || d_req);
    // On a conflict the side that did not win last time is served.
    sel_i    = i_req && (!d_req || !last_grant_i);
    cap_addr  = line_align(sel_i ? i_pmem_address : d_pmem_address);
    cap_write = !sel_i && d_pmem_write;
    cap_wdata = sel_i ? '0 : d_pmem_wdata;
  end

  arb_req_reg u_req_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .addr_in  (cap_addr),
    .write_in (cap_write),
    .wdata_in (cap_wdata),
    .addr     (pmem_address),
    .write    (op_write),
    .wdata    (pmem_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= arb_idle;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      arb_idle: begin
        if (load) begin
          next_state = sel_i ? arb_grant_i : arb_grant_d;
        end
      end
      arb_grant_i, arb_grant_d: begin
        if (pmem_resp) begin
          next_state = arb_recover;
        end
      end
      arb_recover: next_state = arb_idle;
      default:     next_state = arb_idle;
    endcase
  end

  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      arb_grant_i: begin
        pmem_read   = !op_write;
        pmem_write  = op_write;
        i_pmem_resp = pmem_resp;
      end
      arb_grant_d: begin
        pmem_read   = !op_write;
        pmem_write  = op_write;
        d_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_i <= ~I_FIRST;
    end else if (load) begin
      last_grant_i <= sel_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count <= '0;
    end else if (conflict && (conflict_count != '1)) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  conflict_count;

  logic [127:0] s_i_rdata;
  logic         s_i_resp;
  logic [127:0] s_d_rdata;
  logic         s_d_resp;
  logic         s_read;
  logic         s_write;
  logic [15:0]  s_address;
  logic [127:0] s_wdata;
  logic [1:0]   s_count;

  int checks;
  int errors;

  mem_arbiter #(.CNT_WIDTH(16), .I_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_count(conflict_count)
  );

  // Narrow-counter copy fed the same traffic, used for the saturation check.
  mem_arbiter #(.CNT_WIDTH(2), .I_FIRST(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(s_i_rdata), .i_pmem_resp(s_i_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(s_d_rdata), .d_pmem_resp(s_d_resp),
    .pmem_read(s_read), .pmem_write(s_write),
    .pmem_address(s_address), .pmem_wdata(s_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) assert (!(d_pmem_read && d_pmem_write)) else $error("illegal d-cache read+write");
  end

  typedef struct {
    logic         is_i;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic [15:0]  exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after the edge that granted a request; returns at the
  // falling edge of the RECOVER cycle with the granted request dropped.
  task automatic serve(input logic exp_i, input logic exp_wr, input logic [15:0] exp_addr,
                       input logic [127:0] exp_wdata, input logic [127:0] rd);
    @(negedge clk);
    chk("strobe_read", pmem_read, !exp_wr);
    chk("strobe_write", pmem_write, exp_wr);
    chk("address", pmem_address, exp_addr);
    if (exp_wr) chk("wdata", pmem_wdata, exp_wdata);
    chk("early_i_resp", i_pmem_resp, 1'b0);
    chk("early_d_resp", d_pmem_resp, 1'b0);
    if (exp_i) begin
      i_pmem_address = ~i_pmem_address;
    end else begin
      d_pmem_address = ~d_pmem_address;
      d_pmem_wdata   = ~d_pmem_wdata;
    end
    #1;
    chk("address_held", pmem_address, exp_addr);
    if (exp_wr) chk("wdata_held", pmem_wdata, exp_wdata);
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    chk("i_resp", i_pmem_resp, exp_i);
    chk("d_resp", d_pmem_resp, !exp_i);
    chk("i_rdata", i_pmem_rdata, rd);
    chk("d_rdata", d_pmem_rdata, rd);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    if (exp_i) begin
      i_pmem_read = 1'b0;
    end else begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
    @(negedge clk);
    chk("recover_strobes", {pmem_read, pmem_write}, 2'b00);
  endtask

  vec_t         vecs[4];
  logic [15:0]  cur_ia;
  logic [15:0]  cur_da;
  logic [127:0] cur_dw;
  int           n_conf;

  initial begin
    vecs[0] = '{is_i: 1'b1, wr: 1'b0, addr: 16'h1234, wdata: 128'h0,
                rdata: 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, exp_addr: 16'h1230};
    vecs[1] = '{is_i: 1'b0, wr: 1'b1, addr: 16'h8000,
                wdata: 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF,
                rdata: 128'h0, exp_addr: 16'h8000};
    vecs[2] = '{is_i: 1'b0, wr: 1'b0, addr: 16'hABCF, wdata: 128'h5555,
                rdata: 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, exp_addr: 16'hABC0};
    vecs[3] = '{is_i: 1'b1, wr: 1'b0, addr: 16'hFFFF, wdata: 128'h0,
                rdata: 128'h1, exp_addr: 16'hFFF0};

    checks = 0;
    errors = 0;
    n_conf = 0;
    rst = 1'b1;
    i_pmem_read = 1'b0;  i_pmem_address = '0;
    d_pmem_read = 1'b0;  d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0;     pmem_resp = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("rst_address", pmem_address, 16'h0);
    chk("rst_wdata", pmem_wdata, 128'h0);
    chk("rst_count", conflict_count, 16'd0);
    rst = 1'b0;

    // Continuous conflicts: winners alternate I, D, I, D, I.
    cur_ia = 16'h1005;
    cur_da = 16'h200A;
    cur_dw = 128'hA5A5;
    i_pmem_read = 1'b1;  i_pmem_address = cur_ia;
    d_pmem_write = 1'b1; d_pmem_address = cur_da; d_pmem_wdata = cur_dw;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(posedge clk);
      @(posedge clk);
      #1;
      n_conf++;
      chk("conflict_count", conflict_count, 16'(n_conf));
      chk("sat_count", s_count, (n_conf > 3) ? 2'd3 : 2'(n_conf));
      if (k % 2 == 0) begin
        serve(1'b1, 1'b0, cur_ia & 16'hFFF0, 128'h0, 128'(k + 100));
        if (k < 4) begin
          cur_ia = cur_ia + 16'h1111;
          i_pmem_read = 1'b1; i_pmem_address = cur_ia;
        end
      end else begin
        serve(1'b0, 1'b1, cur_da & 16'hFFF0, cur_dw, 128'(k + 200));
        cur_da = cur_da + 16'h0123;
        cur_dw = {cur_dw[63:0], cur_dw[127:64]} ^ 128'h3C;
        d_pmem_write = 1'b1; d_pmem_address = cur_da; d_pmem_wdata = cur_dw;
      end
    end
    // The remaining D request is now alone and must not count as a conflict.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lone_d_count", conflict_count, 16'd5);
    serve(1'b0, 1'b1, cur_da & 16'hFFF0, cur_dw, 128'h77);

    // Stray memory response while idle.
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("stray_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("stray_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("stray_count", conflict_count, 16'd5);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].is_i) begin
        i_pmem_read = 1'b1; i_pmem_address = vecs[v].addr;
      end else begin
        d_pmem_read  = !vecs[v].wr;
        d_pmem_write = vecs[v].wr;
        d_pmem_address = vecs[v].addr;
        d_pmem_wdata   = vecs[v].wdata;
      end
      @(posedge clk);
      serve(vecs[v].is_i, vecs[v].wr, vecs[v].exp_addr, vecs[v].wdata, vecs[v].rdata);
      @(posedge clk);
      #1;
    end
    chk("final_count", conflict_count, 16'd5);
    chk("final_sat_count", s_count, 2'd3);

    // Reset in the middle of a D-cache writeback.
    d_pmem_write = 1'b1; d_pmem_address = 16'h5555; d_pmem_wdata = 128'h99;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_write", pmem_write, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_drop_write", pmem_write, 1'b0);
    chk("rst_drop_count", conflict_count, 16'd0);
    chk("rst_drop_sat", s_count, 2'd0);
    d_pmem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("post_rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("post_rst_strobes", {pmem_read, pmem_write}, 2'b00);

    // Arbiter must be back in IDLE and serve a fresh request.
    i_pmem_read = 1'b1; i_pmem_address = 16'h4321;
    @(posedge clk);
    serve(1'b1, 1'b0, 16'h4320, 128'h0, 128'hBEEF);
    chk("end_count", conflict_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
